// File: rtl/moore_1_decoder_if.sv
// Observation-side bundle for moore_1_decoder: controller code stream in,
// decoded symbols and status out.
interface moore_1_decoder_if #(
  parameter int CNT_W = 8
) ();
  logic             InValid;
  logic [1:0]       OutCode;
  logic             ErrClear;
  logic             DecValid;
  logic [1:0]       DecData;
  logic [1:0]       DecState;
  logic             Locked;
  logic             Err;
  logic [CNT_W-1:0] ErrCount;
  logic [CNT_W-1:0] SymCount;

  modport master (
    output InValid, OutCode, ErrClear,
    input  DecValid, DecData, DecState, Locked, Err, ErrCount, SymCount
  );

  modport slave (
    input  InValid, OutCode, ErrClear,
    output DecValid, DecData, DecState, Locked, Err, ErrCount, SymCount
  );
endinterface

// File: rtl/moore_1_decoder.sv
// Decodes the 4-state Moore controller's output code stream back into its
// state and the input symbol that drove each transition; flags illegal moves.
//
// state        | meaning
// ST_UNLOCKED  | no reference state yet; next valid sample only locks
// ST_TRACK     | reference held; each valid sample is decoded against it
module moore_1_decoder #(
  parameter int CNT_W = 8
) (
  input logic               Clk,
  input logic               Reset,
  moore_1_decoder_if.slave  bus
);
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_TRACK    = 1'b1;

  localparam logic [1:0] S_A = 2'b00;
  localparam logic [1:0] S_B = 2'b01;
  localparam logic [1:0] S_C = 2'b10;
  localparam logic [1:0] S_D = 2'b11;

  logic [0:0]       fsm_q;
  logic             dec_valid_q;
  logic [1:0]       dec_data_q;
  logic [1:0]       dec_state_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] sym_cnt_q;

  logic [1:0]       next_st;
  logic             legal;
  logic [1:0]       tbl_data;

  always_comb begin
    next_st = S_D;
    case (bus.OutCode)
      2'b01:   next_st = S_A;
      2'b00:   next_st = S_B;
      2'b11:   next_st = S_C;
      default: next_st = S_D;
    endcase
  end

  // Reconstructed controller input for each legal (prev, next) pair
  always_comb begin
    legal    = 1'b0;
    tbl_data = 2'b00;
    case ({dec_state_q, next_st})
      {S_A, S_A}: begin legal = 1'b1; tbl_data = 2'b11; end
      {S_A, S_B}: begin legal = 1'b1; tbl_data = 2'b00; end
      {S_B, S_B}: begin legal = 1'b1; tbl_data = 2'b00; end
      {S_B, S_C}: begin legal = 1'b1; tbl_data = 2'b01; end
      {S_C, S_C}: begin legal = 1'b1; tbl_data = 2'b10; end
      {S_C, S_D}: begin legal = 1'b1; tbl_data = 2'b11; end
      {S_D, S_C}: begin legal = 1'b1; tbl_data = 2'b01; end
      {S_D, S_B}: begin legal = 1'b1; tbl_data = 2'b10; end
      default:    begin legal = 1'b0; tbl_data = 2'b00; end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_q       <= ST_UNLOCKED;
      dec_valid_q <= 1'b0;
      dec_data_q  <= 2'b00;
      dec_state_q <= S_A;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      sym_cnt_q   <= '0;
    end else begin
      dec_valid_q <= 1'b0;
      if (bus.ErrClear) begin
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end
      if (bus.InValid) begin
        // Every valid sample becomes the new reference, including after an error
        dec_state_q <= next_st;
        if (fsm_q == ST_UNLOCKED) begin
          fsm_q <= ST_TRACK;
        end else if (legal) begin
          dec_valid_q <= 1'b1;
          dec_data_q  <= tbl_data;
          sym_cnt_q   <= sym_cnt_q + CNT_W'(1);
        end else begin
          err_q <= 1'b1;
          if (bus.ErrClear)
            err_cnt_q <= CNT_W'(1);
          else if (err_cnt_q != '1)
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.DecValid = dec_valid_q;
  assign bus.DecData  = dec_data_q;
  assign bus.DecState = dec_state_q;
  assign bus.Locked   = (fsm_q == ST_TRACK);
  assign bus.Err      = err_q;
  assign bus.ErrCount = err_cnt_q;
  assign bus.SymCount = sym_cnt_q;
endmodule

// File: tb/tb_moore_1_decoder.sv
// Randomized scoreboard bench for moore_1_decoder against a table-driven
// behavioural model of the controller's state/transition map.
module tb_moore_1_decoder;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  moore_1_decoder_if #(.CNT_W(CNT_W)) bus ();

  moore_1_decoder #(.CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // code -> state index (A=0,B=1,C=2,D=3) and state -> code
  int code2st[4];
  int st2code[4];
  // reconstructed input per (prev,next); -1 marks an illegal pair
  int dec_tbl[4][4];

  int m_locked, m_state, m_err, m_errcnt, m_sym, m_data, m_dv;

  typedef struct {
    int data;
    int state;
    int sym;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   obs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model(input bit rst, input bit vld, input int code, input bit clr);
    int n;
    m_dv = 0;
    if (rst) begin
      m_locked = 0; m_state = 0; m_err = 0; m_errcnt = 0; m_sym = 0; m_data = 0;
    end else begin
      if (clr) begin
        m_err = 0; m_errcnt = 0;
      end
      if (vld) begin
        n = code2st[code];
        if (m_locked == 0) begin
          m_locked = 1;
        end else if (dec_tbl[m_state][n] >= 0) begin
          m_data = dec_tbl[m_state][n];
          m_sym  = (m_sym + 1) % (CMAX + 1);
          m_dv   = 1;
          q.push_back('{m_data, n, m_sym, cyc + 1});
        end else begin
          m_err    = 1;
          m_errcnt = (m_errcnt < CMAX) ? m_errcnt + 1 : CMAX;
        end
        m_state = n;
      end
    end
  endtask

  task automatic step(input bit rst, input bit vld, input int code, input bit clr);
    Reset        = rst;
    bus.InValid  = vld;
    bus.OutCode  = code[1:0];
    bus.ErrClear = clr;
    model(rst, vld, code, clr);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".DecValid"}, 32'(bus.DecValid), m_dv);
    chk({tag, ".DecData"},  32'(bus.DecData),  m_data);
    chk({tag, ".DecState"}, 32'(bus.DecState), m_state);
    chk({tag, ".Locked"},   32'(bus.Locked),   m_locked);
    chk({tag, ".Err"},      32'(bus.Err),      m_err);
    chk({tag, ".ErrCount"}, 32'(bus.ErrCount), m_errcnt);
    chk({tag, ".SymCount"}, 32'(bus.SymCount), m_sym);
  endtask

  function automatic int legal_next_code(input int st);
    int cands[$];
    for (int n = 0; n < 4; n++)
      if (dec_tbl[st][n] >= 0) cands.push_back(st2code[n]);
    return cands[$urandom_range(0, cands.size() - 1)];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a decoded symbol
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL mon.missed_pulse: got no DecValid, expected one at cycle %0d", q[0].cyc);
      void'(q.pop_front());
    end
    if (bus.DecValid === 1'b1) begin
      obs.push_back(int'(bus.DecData));
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("mon.DecData",  32'(bus.DecData),  e.data);
        chk("mon.DecState", 32'(bus.DecState), e.state);
        chk("mon.SymCount", 32'(bus.SymCount), e.sym);
      end else begin
        checks++;
        errors++;
        $display("FAIL mon.unexpected_pulse: got DecValid=1 at cycle %0d, expected 0", cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq1[6];
    int gseq[40];
    int run1[$];
    int r;
    int c;

    code2st = '{1, 0, 3, 2};
    st2code = '{1, 0, 3, 2};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        dec_tbl[i][j] = -1;
    dec_tbl[0][0] = 3; dec_tbl[0][1] = 0;
    dec_tbl[1][1] = 0; dec_tbl[1][2] = 1;
    dec_tbl[2][2] = 2; dec_tbl[2][3] = 3;
    dec_tbl[3][2] = 1; dec_tbl[3][1] = 2;

    Reset = 1'b1; bus.InValid = 1'b0; bus.OutCode = 2'b00; bus.ErrClear = 1'b0;
    step(1, 0, 0, 0);
    step(1, 1, 3, 1);
    check_all("reset");

    // Basic decode run
    seq1 = '{1, 1, 0, 3, 2, 3};
    foreach (seq1[i]) begin
      step(0, 1, seq1[i], 0);
      if (i == 0) chk("seq1.lock_first", 32'(bus.Locked), 1);
    end
    check_all("seq1");
    chk("seq1.sym5", 32'(bus.SymCount), 5);
    chk("seq1.stateC", 32'(bus.DecState), 2);

    // C -> A is illegal; then A -> B decodes 00
    step(0, 1, 1, 0);
    check_all("illegal_CA");
    chk("illegal_CA.err", 32'(bus.ErrCount), 1);
    step(0, 1, 0, 0);
    check_all("after_relock");

    // Saturation: alternate 01/10, every transition illegal
    for (int i = 0; i < 256; i++) step(0, 1, (i % 2 == 1) ? 2 : 1, 0);
    check_all("saturate");
    chk("saturate.max", 32'(bus.ErrCount), CMAX);
    step(0, 0, 0, 1);
    check_all("clear");
    chk("clear.zero", 32'(bus.ErrCount), 0);

    // ErrClear coincident with illegal D -> A: detection wins
    step(0, 1, 1, 1);
    check_all("clr_vs_err");
    chk("clr_vs_err.cnt1", 32'(bus.ErrCount), 1);

    // Same code sequence with and without idle gaps must decode identically
    for (int i = 0; i < 40; i++) gseq[i] = $urandom_range(0, 3);
    step(1, 0, 0, 0);
    obs.delete();
    foreach (gseq[i]) begin
      step(0, 1, gseq[i], 0);
      check_all("nogap");
    end
    step(0, 0, 0, 0);
    run1 = obs;
    step(1, 0, 0, 0);
    obs.delete();
    foreach (gseq[i]) begin
      step(0, 1, gseq[i], 0);
      check_all("gap.sample");
      r = $urandom_range(0, 3);
      for (int g = 0; g < r; g++) begin
        step(0, 0, $urandom_range(0, 3), 0);
        check_all("gap.idle");
      end
    end
    step(0, 0, 0, 0);
    chk("gap.count", obs.size(), run1.size());
    for (int i = 0; i < run1.size() && i < obs.size(); i++)
      chk("gap.symbol", obs[i], run1[i]);

    // Reset mid-stream with InValid high, then relock only
    step(0, 1, 3, 0);
    step(0, 1, 2, 0);
    step(1, 1, 0, 0);
    check_all("midreset");
    chk("midreset.unlocked", 32'(bus.Locked), 0);
    step(0, 1, 0, 0);
    check_all("relock");
    chk("relock.nodv", 32'(bus.DecValid), 0);

    // SymCount wrap: B->B repeated 299 times after lock
    step(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0);
    check_all("wrap");
    chk("wrap.value", 32'(bus.SymCount), 299 % 256);

    // Random mixed traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 999);
      if (m_locked != 0 && $urandom_range(0, 9) < 7) c = legal_next_code(m_state);
      else c = $urandom_range(0, 3);
      step(r < 3, $urandom_range(0, 99) < 85, c, $urandom_range(0, 19) == 0);
      check_all("rand");
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
